rv32_alu_issue: RTL and testbench
=================================

// Module: rv32_alu_issue
// PURPOSE
//  Instruction-side driver for the combinational RV32I ALU. Accepts one 32-bit
//  OP/OP-IMM instruction per valid/ready handshake and reads rs1/rs2 from an
//  internal 32x32 register file. Drives alu_operand1/alu_operand2/alu_operation
//  ({funct7[5], funct3} encoding), captures alu_result and writes it back to rd.
//  Sits between fetch and the ALU; one instruction in flight at a time.
// PARAMETERS
//  XLEN      32  datapath width; fixed at 32 for RV32I
//  NREGS     32  register count; x0 is hardwired to zero
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous, active-high reset
//  instr          in   32  instruction word, sampled on accept
//  instr_valid    in   1   instr is valid
//  instr_ready    out  1   block can accept; high only in IDLE
//  alu_operand1   out  32  registered rs1 value to ALU
//  alu_operand2   out  32  registered rs2 value, sign-extended imm, or shamt
//  alu_operation  out  4   registered {funct7[5], funct3} code to ALU
//  alu_result     in   32  combinational ALU result
//  retire_valid   out  1   one-cycle pulse: instruction written back
//  retire_rd      out  5   destination register of retired instruction
//  retire_data    out  32  value written (alu_result)
//  illegal        out  1   one-cycle pulse: accepted instruction rejected
//  dbg_addr       in   5   debug register read address
//  dbg_data       out  32  combinational regfile[dbg_addr]; 0 for x0
// BEHAVIOUR
//  Reset (async): state=IDLE; regfile all 0; alu_* outputs, retire_*, illegal = 0.
//  FSM IDLE -> READ -> EXEC -> IDLE; illegal path READ -> IDLE.
//  IDLE: instr_ready=1; accept on instr_valid&instr_ready; latch instr; -> READ.
//  READ: decode + regfile read; if legal, register alu_operand1/2/operation,
//    -> EXEC; if illegal, illegal=1 next cycle, no ALU update, no write, -> IDLE.
//  EXEC: ALU settles; at edge write regfile[rd]=alu_result (skip if rd==0),
//    retire_valid=1/retire_rd/retire_data set for the following cycle, -> IDLE.
//  Latency: accept at edge N -> retire_valid high in cycle after edge N+2.
//    Throughput 1 instr / 3 cycles; accept allowed in the same cycle retire_valid is high.
//  RAW hazard: none; write lands before next READ.
//  Decode, opcode 0110011 (OP): operand2=rs2; operation={instr[30],funct3}.
//    funct7 must be 0000000, or 0100000 only with funct3 000/101; else illegal.
//  Decode, opcode 0010011 (OP-IMM): operand2={{20{instr[31]}},instr[31:20]}.
//    funct3 001: imm[11:5] must be 0000000; operation=0001; operand2={27'd0,shamt}.
//    funct3 101: imm[11:5] 0000000 -> 0101, 0100000 -> 1101; else illegal;
//      operand2={27'd0,shamt}.
//    other funct3: operation={1'b0,funct3} (no SUBI; instr[30] ignored).
//  Any other opcode: illegal.
//  alu_* outputs hold last value outside READ->EXEC update; retire_valid/illegal
//    are 0 in every cycle except their single pulse cycle.
//  x0: reads return 0; writes discarded but retire_valid still pulses with retire_rd=0.
//  Reset mid-operation: aborts in-flight instruction, no write-back, no pulse.
//  instr_valid while not ready: ignored; instr may change freely.
// TESTING
//  ADDI x1,x0,-16 (0xFF000093) -> operation=0000, op2=0xFFFFFFF0; retire x1=0xFFFFFFF0 at N+3.
//  SRAI x2,x1,4 (0x4040D113) -> operation=1101, op2=4; x2=0xFFFFFFFF.
//  SUB x3,x1,x2 (0x402081B3) -> operation=1000; x3=0xFFFFFFF1; dbg_addr=3 reads it.
//  MUL-encoded 0x022081B3 -> illegal pulse, no retire_valid, x3 unchanged.
//  ADDI x0,x0,7 (0x00700013) -> retire_valid, retire_rd=0; dbg x0 reads 0.
//  Reset asserted during EXEC of ADDI x4,x0,9 -> no retire, x4=0, instr_ready=1 after release.

Source files
------------

// File: rtl/rv32_alu_issue.sv
// Issue stage for the combinational RV32I ALU. The stage accepts one OP or
// OP-IMM instruction, reads its sources from the internal register file,
// presents the operands to the ALU, and writes the result back to rd.
// Only one instruction is in flight: IDLE -> READ -> EXEC -> IDLE.
module rv32_alu_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  output logic [3:0]      alu_operation,
  input  logic [XLEN-1:0] alu_result,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  state_t          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [3:0]      opn_q, opn_d;
  logic            retire_valid_q, retire_valid_d;
  logic [4:0]      retire_rd_q, retire_rd_d;
  logic [XLEN-1:0] retire_data_q, retire_data_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic            rf_we;

  // Instruction fields of the latched instruction
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_sext, shamt_ext;
  logic            dec_legal;
  logic [XLEN-1:0] dec_op2;
  logic [3:0]      dec_opn;

  assign opcode    = instr_q[6:0];
  assign rd        = instr_q[11:7];
  assign funct3    = instr_q[14:12];
  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign funct7    = instr_q[31:25];
  assign rs1_val   = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign imm_sext  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign shamt_ext = {{(XLEN-5){1'b0}}, instr_q[24:20]};

  assign instr_ready   = (state_q == IDLE);
  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_operation = opn_q;
  assign retire_valid  = retire_valid_q;
  assign retire_rd     = retire_rd_q;
  assign retire_data   = retire_data_q;
  assign illegal       = illegal_q;
  assign dbg_data      = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

  // Decode the latched instruction into legality, operand2 and ALU code
  always_comb begin
    dec_legal = 1'b0;
    dec_op2   = rs2_val;
    dec_opn   = {instr_q[30], funct3};
    if (opcode == OPC_OP) begin
      dec_op2   = rs2_val;
      dec_opn   = {instr_q[30], funct3};
      dec_legal = (funct7 == F7_ZERO) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (opcode == OPC_OP_IMM) begin
      case (funct3)
        3'b001: begin
          dec_op2   = shamt_ext;
          dec_opn   = 4'b0001;
          dec_legal = (funct7 == F7_ZERO);
        end
        3'b101: begin
          dec_op2   = shamt_ext;
          dec_opn   = (funct7 == F7_ALT) ? 4'b1101 : 4'b0101;
          dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        end
        default: begin
          dec_op2   = imm_sext;
          dec_opn   = {1'b0, funct3};
          dec_legal = 1'b1;
        end
      endcase
    end
  end

  // Next-state and registered-output logic of the issue FSM
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    op1_d          = op1_q;
    op2_d          = op2_q;
    opn_d          = opn_q;
    retire_valid_d = 1'b0;
    retire_rd_d    = retire_rd_q;
    retire_data_d  = retire_data_q;
    illegal_d      = 1'b0;
    rf_we          = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = READ;
        end
      end
      READ: begin
        if (dec_legal) begin
          op1_d   = rs1_val;
          op2_d   = dec_op2;
          opn_d   = dec_opn;
          state_d = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end
      end
      EXEC: begin
        rf_we          = (rd != 5'd0);
        retire_valid_d = 1'b1;
        retire_rd_d    = rd;
        retire_data_d  = alu_result;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      opn_q          <= '0;
      retire_valid_q <= 1'b0;
      retire_rd_q    <= '0;
      retire_data_q  <= '0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      opn_q          <= opn_d;
      retire_valid_q <= retire_valid_d;
      retire_rd_q    <= retire_rd_d;
      retire_data_q  <= retire_data_d;
      illegal_q      <= illegal_d;
    end
  end

  // Register file write-back; x0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[rd] <= alu_result;
    end
  end

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Scoreboard bench for rv32_alu_issue: a reference model pushes the expected
// pulse for each issued instruction, a monitor pops and compares on pulses.
module tb_rv32_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_operand1, alu_operand2, alu_result;
  logic [3:0]  alu_operation;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  rv32_alu_issue #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_operation(alu_operation),
    .alu_result(alu_result), .retire_valid(retire_valid),
    .retire_rd(retire_rd), .retire_data(retire_data), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External combinational ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_operation)
      4'b0000: alu_result = alu_operand1 + alu_operand2;
      4'b1000: alu_result = alu_operand1 - alu_operand2;
      4'b0001: alu_result = alu_operand1 << alu_operand2[4:0];
      4'b0010: alu_result = {31'b0, $signed(alu_operand1) < $signed(alu_operand2)};
      4'b0011: alu_result = {31'b0, alu_operand1 < alu_operand2};
      4'b0100: alu_result = alu_operand1 ^ alu_operand2;
      4'b0101: alu_result = alu_operand1 >> alu_operand2[4:0];
      4'b1101: alu_result = $signed(alu_operand1) >>> alu_operand2[4:0];
      4'b0110: alu_result = alu_operand1 | alu_operand2;
      4'b0111: alu_result = alu_operand1 & alu_operand2;
      default: alu_result = 32'h0;
    endcase
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ill;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  op;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mreg [32];
  logic [31:0] last_op1, last_op2;
  logic [3:0]  last_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Architectural model: executes the instruction by its RV32I meaning
  task automatic model_push(input logic [31:0] ins, input int acc);
    exp_t        e;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, res;
    logic [3:0]  op;
    bit          legal, is_op;
    opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a = mreg[rs1];
    b = 32'h0; op = 4'h0; legal = 0; res = 32'h0;
    is_op = (opc == 7'b0110011);
    if (is_op) begin
      b = mreg[rs2];
      op = {ins[30], f3};
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (opc == 7'b0010011) begin
      if (f3 == 3'd1) begin
        legal = (f7 == 7'h00); b = {27'b0, rs2}; op = 4'b0001;
      end else if (f3 == 3'd5) begin
        legal = (f7 == 7'h00) || (f7 == 7'h20); b = {27'b0, rs2};
        op = (f7 == 7'h20) ? 4'b1101 : 4'b0101;
      end else begin
        legal = 1; b = {{20{ins[31]}}, ins[31:20]}; op = {1'b0, f3};
      end
    end
    case (f3)
      3'd0: if (is_op && ins[30]) res = a - b; else res = a + b;
      3'd1: res = a << b[4:0];
      3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: if (ins[30]) res = $signed(a) >>> b[4:0]; else res = a >> b[4:0];
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    e.ill = !legal;
    e.rd = rd;
    e.data = res;
    if (legal) begin
      last_op1 = a; last_op2 = b; last_op = op;
      if (rd != 5'd0) mreg[rd] = res;
      e.due = acc + 2;
    end else begin
      e.due = acc + 1;
    end
    e.op1 = last_op1; e.op2 = last_op2; e.op = last_op;
    sbq.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (retire_valid || illegal)) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_pulse retire_valid=%0b illegal=%0b expected no pulse",
                 retire_valid, illegal);
      end else begin
        e = sbq.pop_front();
        chk("pulse_kind", {30'b0, retire_valid, illegal}, e.ill ? 32'd1 : 32'd2);
        chk("pulse_cycle", cyc, e.due);
        chk("alu_operand1", alu_operand1, e.op1);
        chk("alu_operand2", alu_operand2, e.op2);
        chk("alu_operation", {28'b0, alu_operation}, {28'b0, e.op});
        if (!e.ill) begin
          chk("retire_rd", {27'b0, retire_rd}, {27'b0, e.rd});
          chk("retire_data", retire_data, e.data);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins);
    int w;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout instr_ready=0 expected 1 within 20 cycles");
      return;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    model_push(ins, cyc);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_ready) break;
      instr = $urandom;
      instr_valid = 1'($urandom_range(0, 1));
    end
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", sbq.size(), 32'd0);
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] w;
    int unsigned k, r;
    w = $urandom;
    k = $urandom_range(0, 99);
    r = $urandom_range(0, 9);
    if ($urandom_range(0, 1) == 1) begin
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
    end
    if (k < 45) begin
      w[6:0] = 7'b0110011;
      if (r < 5) w[31:25] = 7'h00; else if (r < 9) w[31:25] = 7'h20;
    end else if (k < 92) begin
      w[6:0] = 7'b0010011;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
        if (r < 5) w[31:25] = 7'h00; else if (r < 9) w[31:25] = 7'h20;
      end
    end
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; instr = '0; instr_valid = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    last_op1 = '0; last_op2 = '0; last_op = '0;
    repeat (2) @(negedge clk);
    chk("reset_instr_ready", {31'b0, instr_ready}, 32'd1);
    chk("reset_operand1", alu_operand1, 32'd0);
    chk("reset_operand2", alu_operand2, 32'd0);
    chk("reset_operation", {28'b0, alu_operation}, 32'd0);
    chk("reset_retire_valid", {31'b0, retire_valid}, 32'd0);
    chk("reset_retire_data", retire_data, 32'd0);
    chk("reset_illegal", {31'b0, illegal}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(32'hFF000093);
    issue(32'h4040D113);
    issue(32'h402081B3);
    drain();
    dbg_addr = 5'd1; #1 chk("dbg_x1", dbg_data, 32'hFFFFFFF0);
    dbg_addr = 5'd2; #1 chk("dbg_x2", dbg_data, 32'hFFFFFFFF);
    dbg_addr = 5'd3; #1 chk("dbg_x3", dbg_data, 32'hFFFFFFF1);
    @(negedge clk);
    issue(32'h022081B3);
    issue(32'h00700013);
    drain();
    dbg_addr = 5'd3; #1 chk("dbg_x3_after_illegal", dbg_data, 32'hFFFFFFF1);
    dbg_addr = 5'd0; #1 chk("dbg_x0", dbg_data, 32'd0);
    @(negedge clk);

    repeat (300) issue(gen());
    drain();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk($sformatf("dbg_reg_x%0d", i), dbg_data, mreg[i]);
    end
    @(negedge clk);

    // Reset during EXEC of ADDI x4,x0,9
    instr = 32'h00900213;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midreset_retire_valid", {31'b0, retire_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    last_op1 = '0; last_op2 = '0; last_op = '0;
    @(negedge clk);
    chk("postreset_instr_ready", {31'b0, instr_ready}, 32'd1);
    dbg_addr = 5'd4; #1 chk("postreset_x4", dbg_data, 32'd0);
    repeat (3) @(negedge clk);
    chk("postreset_no_retire", {31'b0, retire_valid}, 32'd0);

    issue(32'h00900213);
    drain();
    dbg_addr = 5'd4; #1 chk("after_reset_x4", dbg_data, 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
